// File: rtl/serial_replay_buffer.sv
// serial_replay_buffer: UART-style capture buffer with optional echo and whole-message replay
module serial_replay_buffer #(
   parameter int CLK_DIV = 10417,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = 6,
   parameter int ECHO    = 1
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              rx,
   input  logic              play,
   input  logic              clear,
   output logic              tx,
   output logic              busy,
   output logic              replaying,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow,
   output logic              frame_err
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0]   BIT_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]   HALF_END = CW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e            rx_st_q, rx_st_d, tx_st_q, tx_st_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]     rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d;
   logic              rx_valid_q, rx_valid_d, rep_q, rep_d, ovf_q, ovf_d, ferr_q, ferr_d;
   logic              store, bad, store_ok;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [ADDR_W:0]   count_q, count_d, rd_q, rd_d, end_q, end_d, rd_nxt;
   logic [DATA_W-1:0] mem_q [DEPTH];

   assign full     = count_q == FULL_CNT;
   assign store_ok = store && !full && !clear;
   assign rd_nxt   = rd_q + 1'b1;

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      store      = 1'b0;
      bad        = 1'b0;
      case (rx_st_q)
         IDLE: begin
            rx_cnt_d = '0;
            if (!rx) rx_st_d = START;
         end
         START: if (rx_cnt_q == HALF_END) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx ? IDLE : DATA;
         end
         DATA: if (rx_cnt_q == BIT_END) begin
            rx_cnt_d = '0;
            rx_sh_d  = DATA_W'({rx, rx_sh_q} >> 1);
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == LAST_BIT) rx_st_d = STOP;
         end
         STOP: if (rx_cnt_q == BIT_END) begin
            rx_st_d    = IDLE;
            rx_valid_d = rx;
            store      = rx;
            bad        = !rx;
            rx_data_d  = rx ? rx_sh_q : rx_data_q;
         end
      endcase
   end

   always_comb begin
      wr_d    = clear ? '0 : store_ok ? wr_q + 1'b1 : wr_q;
      count_d = clear ? '0 : store_ok ? count_q + 1'b1 : count_q;
      ovf_d   = !clear && (ovf_q || (store && full));
      ferr_d  = !clear && (ferr_q || bad);
   end

   // Memory is read combinationally so each replayed frame starts right after the previous stop bit
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      rd_d     = rd_q;
      end_d    = end_q;
      rep_d    = rep_q;
      case (tx_st_q)
         IDLE: begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (play && count_q != '0) begin
               rep_d   = 1'b1;
               end_d   = count_q;
               rd_d    = '0;
               tx_sh_d = mem_q[ADDR_W'(0)];
               tx_st_d = START;
            end else if (ECHO != 0 && rx_valid_q) begin
               tx_sh_d = rx_data_q;
               tx_st_d = START;
            end
         end
         START: if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            tx_st_d  = DATA;
         end
         DATA: if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == LAST_BIT) tx_st_d = STOP;
         end
         STOP: if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (rep_q && rd_nxt < end_q) begin
               rd_d    = rd_nxt;
               tx_sh_d = mem_q[rd_nxt[ADDR_W-1:0]];
               tx_st_d = START;
            end else begin
               rep_d   = 1'b0;
               tx_st_d = IDLE;
            end
         end
      endcase
      if (clear) begin
         tx_st_d = IDLE;
         rep_d   = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_st_q    <= IDLE;
         tx_st_q    <= IDLE;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         tx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         tx_sh_q    <= '0;
         rx_valid_q <= 1'b0;
         rep_q      <= 1'b0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
         wr_q       <= '0;
         count_q    <= '0;
         rd_q       <= '0;
         end_q      <= '0;
      end else begin
         rx_st_q    <= rx_st_d;
         tx_st_q    <= tx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         tx_bit_q   <= tx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         tx_sh_q    <= tx_sh_d;
         rx_valid_q <= rx_valid_d;
         rep_q      <= rep_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         rd_q       <= rd_d;
         end_q      <= end_d;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reset && store_ok) mem_q[wr_q] <= rx_sh_q;
   end

   assign tx        = (tx_st_q == START) ? 1'b0 : (tx_st_q == DATA) ? tx_sh_q[0] : 1'b1;
   assign busy      = tx_st_q != IDLE;
   assign replaying = rep_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign frame_err = ferr_q;
endmodule
